// File: rtl/pddt_pkg.sv
// Shared types and defaults for the trigger path of the programmable delay timer.
package pddt_pkg;

  localparam int DEF_CNT_W       = 8;
  localparam int DEF_SYNC_STAGES = 2;

  // Debounce FSM states; clean level is high in STABLE_HI and QUAL_LO
  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    QUAL_HI   = 2'd1,
    STABLE_HI = 2'd2,
    QUAL_LO   = 2'd3
  } cond_state_t;

endpackage

// File: rtl/sync_bit.sv
// Single-bit flop-chain synchroniser for an asynchronous input.
module sync_bit #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] chain;

  // Shift the raw input through the chain; stage 0 is the metastability catcher
  always_ff @(posedge clk) begin
    if (reset) chain <= '0;
    else       chain <= {chain[SYNC_STAGES-2:0], d};
  end

  assign q = chain[SYNC_STAGES-1];

endmodule

// File: rtl/trigger_conditioner.sv
// Synchronises, polarity-corrects and debounces the external trigger, emitting a
// clean level plus rise/fall strobes with retrigger hold-off and a glitch counter.
module trigger_conditioner
  import pddt_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             trig_raw,
  input  logic             polarity,
  input  logic             enable,
  input  logic [CNT_W-1:0] filt_len,
  input  logic [CNT_W-1:0] holdoff_len,
  output logic             trig_clean,
  output logic             trig_rise,
  output logic             trig_fall,
  output logic             holdoff_active,
  output logic [CNT_W-1:0] glitch_cnt
);

  logic             sync_q;
  logic             s;
  logic [CNT_W-1:0] n_m1;
  logic             qual_one;

  cond_state_t      state, state_nxt;
  logic [CNT_W-1:0] qual_cnt, qual_nxt;
  logic [CNT_W-1:0] hold_cnt, hold_nxt;
  logic             rise_go, fall_go, glitch_inc, rise_emit;

  sync_bit #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (trig_raw),
    .q     (sync_q)
  );

  // Polarity is applied after the synchroniser so the chain only sees the pin
  assign s        = sync_q ^ polarity;
  // filt_len of 0 behaves like 1, so N-1 bottoms out at 0
  assign n_m1     = (filt_len == '0) ? '0 : filt_len - CNT_W'(1);
  assign qual_one = (n_m1 == '0);

  // Next-state, qualification count and strobe decisions
  always_comb begin
    state_nxt  = state;
    qual_nxt   = qual_cnt;
    rise_go    = 1'b0;
    fall_go    = 1'b0;
    glitch_inc = 1'b0;
    if (!enable) begin
      // Freeze: abandon any qualification without counting it as a glitch
      qual_nxt = '0;
      case (state)
        QUAL_HI: state_nxt = STABLE_LO;
        QUAL_LO: state_nxt = STABLE_HI;
        default: state_nxt = state;
      endcase
    end else begin
      case (state)
        STABLE_LO: if (s) begin
          if (qual_one) begin
            state_nxt = STABLE_HI;
            rise_go   = 1'b1;
          end else begin
            state_nxt = QUAL_HI;
            qual_nxt  = CNT_W'(1);
          end
        end
        QUAL_HI: begin
          if (s) begin
            // >= so a shortened filt_len completes an in-flight qualification
            if (qual_cnt >= n_m1) begin
              state_nxt = STABLE_HI;
              qual_nxt  = '0;
              rise_go   = 1'b1;
            end else begin
              qual_nxt = qual_cnt + CNT_W'(1);
            end
          end else begin
            state_nxt  = STABLE_LO;
            qual_nxt   = '0;
            glitch_inc = 1'b1;
          end
        end
        STABLE_HI: if (!s) begin
          if (qual_one) begin
            state_nxt = STABLE_LO;
            fall_go   = 1'b1;
          end else begin
            state_nxt = QUAL_LO;
            qual_nxt  = CNT_W'(1);
          end
        end
        QUAL_LO: begin
          if (!s) begin
            if (qual_cnt >= n_m1) begin
              state_nxt = STABLE_LO;
              qual_nxt  = '0;
              fall_go   = 1'b1;
            end else begin
              qual_nxt = qual_cnt + CNT_W'(1);
            end
          end else begin
            state_nxt  = STABLE_HI;
            qual_nxt   = '0;
            glitch_inc = 1'b1;
          end
        end
        default: begin
          state_nxt = STABLE_LO;
          qual_nxt  = '0;
        end
      endcase
    end
  end

  // Hold-off only gates the strobe; the level change still goes through
  assign rise_emit = rise_go && (hold_cnt == '0);
  assign hold_nxt  = rise_emit          ? holdoff_len :
                     (hold_cnt != '0)   ? hold_cnt - CNT_W'(1) : '0;

  // State, counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= STABLE_LO;
      qual_cnt       <= '0;
      hold_cnt       <= '0;
      trig_clean     <= 1'b0;
      trig_rise      <= 1'b0;
      trig_fall      <= 1'b0;
      holdoff_active <= 1'b0;
      glitch_cnt     <= '0;
    end else begin
      state          <= state_nxt;
      qual_cnt       <= qual_nxt;
      hold_cnt       <= hold_nxt;
      trig_clean     <= (state_nxt == STABLE_HI) || (state_nxt == QUAL_LO);
      trig_rise      <= rise_emit;
      trig_fall      <= fall_go;
      holdoff_active <= (hold_nxt != '0);
      if (glitch_inc && (glitch_cnt != '1)) glitch_cnt <= glitch_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_trigger_conditioner.sv
// Directed scoreboard bench for trigger_conditioner: expectations are queued by
// cycle number as stimulus is driven and compared on the falling edge.
module tb_trigger_conditioner;

  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             trig_raw;
  logic             polarity;
  logic             enable;
  logic [CNT_W-1:0] filt_len;
  logic [CNT_W-1:0] holdoff_len;
  logic             trig_clean, trig_rise, trig_fall, holdoff_active;
  logic [CNT_W-1:0] glitch_cnt;

  trigger_conditioner #(.SYNC_STAGES(2), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .trig_raw       (trig_raw),
    .polarity       (polarity),
    .enable         (enable),
    .filt_len       (filt_len),
    .holdoff_len    (holdoff_len),
    .trig_clean     (trig_clean),
    .trig_rise      (trig_rise),
    .trig_fall      (trig_fall),
    .holdoff_active (holdoff_active),
    .glitch_cnt     (glitch_cnt)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int              at;
    logic [CNT_W+3:0] val;   // {clean, rise, fall, holdoff_active, glitch_cnt}
    string           tag;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic exp1(input int at, input logic c, input logic r, input logic f,
                      input logic h, input logic [CNT_W-1:0] g, input string tag);
    exp_t e;
    int   i;
    e.at  = at;
    e.val = {c, r, f, h, g};
    e.tag = tag;
    i = sb.size();
    while (i > 0 && sb[i-1].at > at) i--;
    sb.insert(i, e);
  endtask

  task automatic expr(input int a, input int b, input logic c, input logic r, input logic f,
                      input logic h, input logic [CNT_W-1:0] g, input string tag);
    for (int t = a; t <= b; t++) exp1(t, c, r, f, h, g, tag);
  endtask

  function automatic logic [CNT_W-1:0] sat(input int x);
    return (x > 255) ? 8'd255 : x[CNT_W-1:0];
  endfunction

  // Hold-off window for the pulse-train test, relative to the first emitted rise
  function automatic logic hof(input int rel);
    return ((rel >= 0) && (rel <= 9)) || ((rel >= 12) && (rel <= 21));
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard: pop every expectation due at this cycle and compare
  always @(negedge clk) begin
    exp_t             e;
    logic [CNT_W+3:0] obs;
    obs = {trig_clean, trig_rise, trig_fall, holdoff_active, glitch_cnt};
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      checks++;
      assert (e.at === cyc) else begin
        errors++;
        $error("FAIL %s: expectation for cycle %0d reached only at cycle %0d", e.tag, e.at, cyc);
      end
      if (e.at == cyc) begin
        assert (obs === e.val) else begin
          errors++;
          $error("FAIL %s cyc=%0d got {c,r,f,h,g}=%b_%b_%b_%b_%0d expected %b_%b_%b_%b_%0d",
                 e.tag, cyc, obs[11], obs[10], obs[9], obs[8], obs[7:0],
                 e.val[11], e.val[10], e.val[9], e.val[8], e.val[7:0]);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k0, kb;

    reset = 1'b1; trig_raw = 1'b0; polarity = 1'b0; enable = 1'b1;
    filt_len = 8'd4; holdoff_len = 8'd0;
    expr(1, 3, 0, 0, 0, 0, 0, "reset_state");
    tick(3);
    reset = 1'b0;

    // Rise with N=4: visible 5 edges after capture
    k = cyc;
    trig_raw = 1'b1;
    expr(k+1, k+5, 0, 0, 0, 0, 0, "n4_pre_rise");
    exp1(k+6, 1, 1, 0, 0, 0, "n4_rise");
    expr(k+7, k+20, 1, 0, 0, 0, 0, "n4_high");
    tick(20);
    k = cyc;
    trig_raw = 1'b0;
    expr(k+1, k+5, 1, 0, 0, 0, 0, "n4_pre_fall");
    exp1(k+6, 0, 0, 1, 0, 0, "n4_fall");
    expr(k+7, k+9, 0, 0, 0, 0, 0, "n4_low");
    tick(10);

    // 3-cycle pulses with N=4: each adds one glitch, saturating at 255
    for (int i = 0; i < 300; i++) begin
      k = cyc;
      trig_raw = 1'b1;
      expr(k+1, k+5, 0, 0, 0, 0, sat(i), "glitch_pre");
      exp1(k+6, 0, 0, 0, 0, sat(i+1), "glitch_inc");
      tick(3);
      trig_raw = 1'b0;
      tick(3);
    end

    // Reset clears the saturated glitch counter
    reset = 1'b1;
    filt_len = 8'd1; holdoff_len = 8'd10;
    exp1(cyc+1, 0, 0, 0, 0, 0, "reset_glitch_clear");
    tick(1);

    // N=1, hold-off 10, pulse every 4 cycles: rises on pulses 0 and 3 only
    reset = 1'b0;
    k = cyc;
    expr(k+1, k+2, 0, 0, 0, 0, 0, "ho_pre");
    for (int i = 0; i < 5; i++) begin
      kb = k + 4*i;
      exp1(kb+3, 1, (i == 0 || i == 3), 0, hof(kb+3-(k+3)), 0, "ho_rise");
      exp1(kb+4, 1, 0, 0, hof(kb+4-(k+3)), 0, "ho_high");
      exp1(kb+5, 0, 0, 1, hof(kb+5-(k+3)), 0, "ho_fall");
      exp1(kb+6, 0, 0, 0, hof(kb+6-(k+3)), 0, "ho_low");
    end
    for (int t = k+23; t <= k+26; t++) exp1(t, 0, 0, 0, hof(t-(k+3)), 0, "ho_tail");
    for (int i = 0; i < 5; i++) begin
      trig_raw = 1'b1;
      tick(2);
      trig_raw = 1'b0;
      tick(2);
    end
    tick(7);

    // Active-low input, N=2; enable held low while the synchroniser fills
    reset = 1'b1; trig_raw = 1'b1; polarity = 1'b1; enable = 1'b0;
    filt_len = 8'd2; holdoff_len = 8'd0;
    k0 = cyc;
    expr(k0+1, k0+3, 0, 0, 0, 0, 0, "pol_reset");
    tick(3);
    reset = 1'b0;
    k0 = cyc;
    expr(k0+1, k0+5, 0, 0, 0, 0, 0, "pol_idle");
    tick(3);
    enable = 1'b1;
    tick(2);
    k = cyc;
    trig_raw = 1'b0;
    expr(k+1, k+3, 0, 0, 0, 0, 0, "pol_pre");
    exp1(k+4, 1, 1, 0, 0, 0, "pol_rise");
    expr(k+5, k+8, 1, 0, 0, 0, 0, "pol_high");
    tick(8);

    // Enable dropped at qualification count 2 of N=5
    reset = 1'b1; polarity = 1'b0; trig_raw = 1'b0; filt_len = 8'd5;
    expr(cyc+1, cyc+2, 0, 0, 0, 0, 0, "en_reset");
    tick(2);
    reset = 1'b0;
    k = cyc;
    trig_raw = 1'b1;
    expr(k+1, k+11, 0, 0, 0, 0, 0, "en_frozen");
    exp1(k+12, 1, 1, 0, 0, 0, "en_rise");
    expr(k+13, k+15, 1, 0, 0, 0, 0, "en_high");
    tick(4);
    enable = 1'b0;
    tick(3);
    enable = 1'b1;
    tick(8);

    // Reset while qualifying low (N=3), raw high afterwards
    filt_len = 8'd3;
    k = cyc;
    trig_raw = 1'b0;
    expr(k+1, k+4, 1, 0, 0, 0, 0, "rq_qual_lo");
    exp1(k+5, 0, 0, 0, 0, 0, "rq_reset");
    expr(k+6, k+9, 0, 0, 0, 0, 0, "rq_refill");
    exp1(k+10, 1, 1, 0, 0, 0, "rq_rise");
    expr(k+11, k+13, 1, 0, 0, 0, 0, "rq_high");
    tick(4);
    reset = 1'b1;
    trig_raw = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(8);

    // filt_len = 0 behaves as N=1
    filt_len = 8'd0;
    k = cyc;
    trig_raw = 1'b0;
    expr(k+1, k+2, 1, 0, 0, 0, 0, "n0_pre");
    exp1(k+3, 0, 0, 1, 0, 0, "n0_fall");
    exp1(k+4, 0, 0, 0, 0, 0, "n0_low");
    tick(6);

    checks++;
    assert (sb.size() === 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: %0d expectations left, required 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
